uart_tx_cfg: RTL and testbench

Parametrised UART transmitter. It replaces the fixed-format bit-timer/sender pair with one block that has configurable baud divider, data width, parity and stop bits. Words arrive over a valid/ready handshake into an internal FIFO and are serialised LSB-first on dout. Upstream producers (string selectors, keyboard/scanner logic) push characters without tracking frame timing.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_cfg.sv | 125 ++++++++++++
 tb/tb_uart_tx_cfg.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int frame_len(
    input int baud_div,
    input int data_bits,
    input int parity,
    input int stop_bits
  );
    return baud_div *
      (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible
// combinationally on pop_data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words framed with
// start, data (LSB first), optional parity and 1..2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 10417,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic                        dout,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter combination");
  end

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e             state;
  tx_state_e             state_nx;
  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic [DATA_BITS-1:0]  shreg;
  logic [DATA_BITS-1:0]  head;
  logic                  par_bit;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  bit_end;
  logic                  last_stop;
  logic                  dout_nx;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (din_valid),
    .push_data (din),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign din_ready = !full;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);
  assign bit_end   = (cnt == CNT_LAST);
  assign last_stop = (state == ST_STOP) && bit_end && (idx == STOP_LAST);

  // dout lags the state by one cycle, so the start bit appears two
  // edges after a word lands in an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      dout    <= 1'b1;
    end else begin
      state <= state_nx;
      dout  <= dout_nx;
      if (pop) begin
        shreg   <= head;
        par_bit <= (PARITY == PAR_ODD) ? ~^head : ^head;
      end else if (state == ST_DATA && bit_end) begin
        shreg <= shreg >> 1;
      end
      if (state_nx != state || state == ST_IDLE) begin
        cnt <= '0;
        idx <= '0;
      end else if (bit_end) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (!empty) state_nx = ST_START;
      ST_START:  if (bit_end) state_nx = ST_DATA;
      ST_DATA:
        if (bit_end && idx == DATA_LAST)
          state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nx = ST_STOP;
      ST_STOP:
        if (last_stop) state_nx = empty ? ST_IDLE : ST_START;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    pop     = !empty && (state == ST_IDLE || last_stop);
    dout_nx = 1'b1;
    unique case (state)
      ST_START:  dout_nx = 1'b0;
      ST_DATA:   dout_nx = shreg[0];
      ST_PARITY: dout_nx = par_bit;
      default:   dout_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: two instances with different
// frame formats, sampled 1-2 ns after each rising edge.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] din_a;
  logic [6:0] din_b;
  logic       din_valid_a, din_valid_b;
  logic       din_ready_a, din_ready_b;
  logic       dout_a, dout_b;
  logic       busy_a, busy_b;
  logic [2:0] fifo_count_a;
  logic [4:0] fifo_count_b;

  int checks = 0;
  int failures = 0;

  logic rec_a [0:511];
  logic rec_b [0:511];
  int   rec_n = 0;
  bit   rec_on = 1'b0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .BAUD_DIV(4), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .din_valid(din_valid_a),
    .din_ready(din_ready_a), .dout(dout_a), .busy(busy_a),
    .fifo_count(fifo_count_a)
  );

  uart_tx_cfg #(
    .BAUD_DIV(4), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .din_valid(din_valid_b),
    .din_ready(din_ready_b), .dout(dout_b), .busy(busy_b),
    .fifo_count(fifo_count_b)
  );

  // rec_x[k] holds dout one ns after the k-th edge following a restart
  always @(posedge clk) begin
    #1;
    if (rec_on && rec_n < 512) begin
      rec_a[rec_n] = dout_a;
      rec_b[rec_n] = dout_b;
      rec_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    din_a = '0; din_b = '0;
    din_valid_a = 1'b0; din_valid_b = 1'b0;
    ticks(2);
    checks++;
    if (dout_a !== 1'b1) begin
      failures++; $display("FAIL reset_dout_a got=%b exp=1", dout_a);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL reset_busy_a got=%b exp=0", busy_a);
    end
    checks++;
    if (din_ready_a !== 1'b1) begin
      failures++; $display("FAIL reset_ready_a got=%b exp=1", din_ready_a);
    end
    checks++;
    if (fifo_count_a !== 3'd0) begin
      failures++; $display("FAIL reset_count_a got=%0d exp=0", fifo_count_a);
    end
    checks++;
    if (dout_b !== 1'b1) begin
      failures++; $display("FAIL reset_dout_b got=%b exp=1", dout_b);
    end
    checks++;
    if (busy_b !== 1'b0) begin
      failures++; $display("FAIL reset_busy_b got=%b exp=0", busy_b);
    end
    checks++;
    if (din_ready_b !== 1'b1) begin
      failures++; $display("FAIL reset_ready_b got=%b exp=1", din_ready_b);
    end
    checks++;
    if (fifo_count_b !== 5'd0) begin
      failures++; $display("FAIL reset_count_b got=%0d exp=0", fifo_count_b);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    ticks(2);
  endtask

  task automatic test_default_format();
    logic [9:0] fr;
    logic [3:0] got4;
    fr = {1'b1, 8'h55, 1'b0};
    din_a = 8'h55; din_valid_a = 1'b1;
    rec_n = 0; rec_on = 1'b1;
    tick();
    din_valid_a = 1'b0;
    checks++;
    if (fifo_count_a !== 3'd1) begin
      failures++; $display("FAIL default_accept got=%0d exp=1", fifo_count_a);
    end
    tick();
    checks++;
    if ({dout_a, busy_a, fifo_count_a} !== {1'b1, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL default_pop got=%b/%b/%0d exp=1/1/0",
               dout_a, busy_a, fifo_count_a);
    end
    ticks(45);
    checks++;
    if ({rec_a[1], rec_a[0]} !== 2'b11) begin
      failures++;
      $display("FAIL default_lead got=%b exp=11", {rec_a[1], rec_a[0]});
    end
    for (int i = 0; i < 10; i++) begin
      got4 = {rec_a[4*i+5], rec_a[4*i+4], rec_a[4*i+3], rec_a[4*i+2]};
      checks++;
      if (got4 !== {4{fr[i]}}) begin
        failures++;
        $display("FAIL default_bit%0d got=%b exp=%b", i, got4, {4{fr[i]}});
      end
    end
    got4 = {rec_a[45], rec_a[44], rec_a[43], rec_a[42]};
    checks++;
    if (got4 !== 4'hf) begin
      failures++; $display("FAIL default_tail got=%b exp=1111", got4);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL default_busy_end got=%b exp=0", busy_a);
    end
    rec_on = 1'b0;
  endtask

  task automatic test_even_parity();
    logic [21:0] fr;
    logic [3:0]  got4;
    // {stop,stop,parity,data[6:0],start} for 0x03 then 0x07
    fr = {2'b11, 1'b1, 7'h07, 1'b0, 2'b11, 1'b0, 7'h03, 1'b0};
    din_b = 7'h03; din_valid_b = 1'b1;
    rec_n = 0; rec_on = 1'b1;
    tick();
    din_b = 7'h07;
    tick();
    din_valid_b = 1'b0;
    checks++;
    if (fifo_count_b !== 5'd1) begin
      failures++; $display("FAIL parity_count got=%0d exp=1", fifo_count_b);
    end
    ticks(94);
    checks++;
    if ({rec_b[1], rec_b[0]} !== 2'b11) begin
      failures++;
      $display("FAIL parity_lead got=%b exp=11", {rec_b[1], rec_b[0]});
    end
    for (int i = 0; i < 22; i++) begin
      got4 = {rec_b[4*i+5], rec_b[4*i+4], rec_b[4*i+3], rec_b[4*i+2]};
      checks++;
      if (got4 !== {4{fr[i]}}) begin
        failures++;
        $display("FAIL parity_f%0d_bit%0d got=%b exp=%b",
                 i / 11, i % 11, got4, {4{fr[i]}});
      end
    end
    got4 = {rec_b[93], rec_b[92], rec_b[91], rec_b[90]};
    checks++;
    if (got4 !== 4'hf) begin
      failures++; $display("FAIL parity_tail got=%b exp=1111", got4);
    end
    checks++;
    if (busy_b !== 1'b0) begin
      failures++; $display("FAIL parity_busy_end got=%b exp=0", busy_b);
    end
    rec_on = 1'b0;
  endtask

  task automatic test_push_pop_same_cycle();
    logic [19:0] fr;
    logic [3:0]  got4;
    fr = {1'b1, 8'h3c, 1'b0, 1'b1, 8'ha5, 1'b0};
    din_a = 8'ha5; din_valid_a = 1'b1;
    rec_n = 0; rec_on = 1'b1;
    tick();
    din_a = 8'h3c;
    tick();
    din_valid_a = 1'b0;
    checks++;
    if (fifo_count_a !== 3'd1) begin
      failures++; $display("FAIL pushpop_count got=%0d exp=1", fifo_count_a);
    end
    ticks(85);
    for (int i = 0; i < 20; i++) begin
      got4 = {rec_a[4*i+5], rec_a[4*i+4], rec_a[4*i+3], rec_a[4*i+2]};
      checks++;
      if (got4 !== {4{fr[i]}}) begin
        failures++;
        $display("FAIL pushpop_f%0d_bit%0d got=%b exp=%b",
                 i / 10, i % 10, got4, {4{fr[i]}});
      end
    end
    checks++;
    if (rec_a[82] !== 1'b1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_end got=%b/%b exp=1/0", rec_a[82], busy_a);
    end
    rec_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    int         nacc;
    int         acc_edge;
    logic       acc;
    logic [9:0] f;
    logic [3:0] got4;
    int         j;
    int         p;
    nacc = 0; acc_edge = -1;
    din_a = 8'h41; din_valid_a = 1'b1;
    rec_n = 0; rec_on = 1'b1;
    for (int i = 0; i < 100 && nacc < 6; i++) begin
      acc = din_ready_a;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 6) begin
          acc_edge = i;
          din_valid_a = 1'b0;
        end else begin
          din_a = 8'(8'h41 + nacc);
        end
      end
      if (i == 4) begin
        checks++;
        if (fifo_count_a !== 3'd4 || din_ready_a !== 1'b0 || nacc != 5) begin
          failures++;
          $display("FAIL b2b_full got=cnt%0d rdy%b acc%0d exp=cnt4 rdy0 acc5",
                   fifo_count_a, din_ready_a, nacc);
        end
      end
    end
    checks++;
    if (acc_edge != 42) begin
      failures++; $display("FAIL b2b_sixth_accept got=%0d exp=42", acc_edge);
    end
    ticks(206);
    for (int i = 0; i < 60; i++) begin
      j = i / 10;
      p = i % 10;
      f = {1'b1, 8'(8'h41 + j), 1'b0};
      got4 = {rec_a[4*i+5], rec_a[4*i+4], rec_a[4*i+3], rec_a[4*i+2]};
      checks++;
      if (got4 !== {4{f[p]}}) begin
        failures++;
        $display("FAIL b2b_f%0d_bit%0d got=%b exp=%b", j, p, got4, {4{f[p]}});
      end
    end
    got4 = {rec_a[245], rec_a[244], rec_a[243], rec_a[242]};
    checks++;
    if (got4 !== 4'hf || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got=%b/%b exp=1111/0", got4, busy_a);
    end
    rec_on = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    din_a = 8'h00; din_valid_a = 1'b1;
    ticks(3);
    din_valid_a = 1'b0;
    ticks(16);
    checks++;
    if (fifo_count_a !== 3'd2 || dout_a !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre got=cnt%0d dout%b exp=cnt2 dout0",
               fifo_count_a, dout_a);
    end
    rst_a = 1'b1;
    tick();
    checks++;
    if ({dout_a, fifo_count_a, busy_a, din_ready_a} !==
        {1'b1, 3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midrst_state got=%b/%0d/%b/%b exp=1/0/0/1",
               dout_a, fifo_count_a, busy_a, din_ready_a);
    end
    rst_a = 1'b0;
    rec_n = 0; rec_on = 1'b1;
    ticks(40);
    rec_on = 1'b0;
    lows = 0;
    for (int i = 0; i < 38; i++) if (rec_a[i] !== 1'b1) lows++;
    checks++;
    if (lows != 0) begin
      failures++; $display("FAIL midrst_quiet got=%0d exp=0", lows);
    end
    din_a = 8'hff; din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
    ticks(2);
    checks++;
    if (dout_a !== 1'b0) begin
      failures++; $display("FAIL midrst_restart got=%b exp=0", dout_a);
    end
    ticks(45);
    checks++;
    if (busy_a !== 1'b0 || dout_a !== 1'b1) begin
      failures++;
      $display("FAIL midrst_end got=%b/%b exp=0/1", busy_a, dout_a);
    end
  endtask

  initial begin
    test_reset();
    test_default_format();
    test_even_parity();
    test_push_pop_same_cycle();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
